// File: rtl/frv_mem_arb_pkg.sv
// Shared encodings for the frv memory arbiter: requester IDs queued per
// accepted request and the request-lock states.
package frv_mem_arb_pkg;

  localparam logic ARB_ID_IMEM = 1'b0;
  localparam logic ARB_ID_DMEM = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } arb_lock_e;

endpackage

// File: rtl/frv_mem_arb_idq.sv
// One-bit ID FIFO recording which requester owns each outstanding request,
// so in-order responses can be routed back.
module frv_mem_arb_idq #(
  parameter int DEPTH = 2
) (
  input  logic g_clk,
  input  logic g_resetn,
  input  logic push,
  input  logic id,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] slots;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = slots[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      slots  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        slots[wr_ptr] <= id;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frv_mem_arbiter.sv
// Round-robin arbiter sharing one downstream memory port between the fetch
// (imem) and load/store (dmem) channels; responses routed via an ID FIFO.
module frv_mem_arbiter
  import frv_mem_arb_pkg::*;
#(
  parameter int OUTSTANDING = 2,
  parameter int XLEN        = 32
) (
  input  logic            g_clk,
  input  logic            g_resetn,

  input  logic            imem_req,
  input  logic            imem_wen,
  input  logic [3:0]      imem_strb,
  input  logic [XLEN-1:0] imem_wdata,
  input  logic [XLEN-1:0] imem_addr,
  output logic            imem_gnt,
  output logic            imem_recv,
  input  logic            imem_ack,
  output logic            imem_error,
  output logic [XLEN-1:0] imem_rdata,

  input  logic            dmem_req,
  input  logic            dmem_wen,
  input  logic [3:0]      dmem_strb,
  input  logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_addr,
  output logic            dmem_gnt,
  output logic            dmem_recv,
  input  logic            dmem_ack,
  output logic            dmem_error,
  output logic [XLEN-1:0] dmem_rdata,

  output logic            mem_req,
  output logic            mem_wen,
  output logic [3:0]      mem_strb,
  output logic [XLEN-1:0] mem_wdata,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_recv,
  input  logic            mem_error,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            mem_ack,

  output logic            arb_err
);

  arb_lock_e lock;
  logic      rr_d;      // 1: dmem wins the next tie
  logic      sel_d;
  logic      sel_req;
  logic      full, empty, head;
  logic      push, pop;
  logic      head_i, head_d;

  // A locked selection is held until the downstream grant.
  always_comb begin
    sel_d = 1'b0;
    case (lock)
      LOCK_I:  sel_d = 1'b0;
      LOCK_D:  sel_d = 1'b1;
      default: sel_d = (imem_req && dmem_req) ? rr_d : dmem_req;
    endcase
  end

  assign sel_req = sel_d ? dmem_req : imem_req;

  // Outputs are forced low while reset is asserted, even mid-transaction.
  assign mem_req   = g_resetn && sel_req && !full;
  assign mem_wen   = g_resetn && (sel_d ? dmem_wen : imem_wen);
  assign mem_strb  = g_resetn ? (sel_d ? dmem_strb  : imem_strb)  : '0;
  assign mem_wdata = g_resetn ? (sel_d ? dmem_wdata : imem_wdata) : '0;
  assign mem_addr  = g_resetn ? (sel_d ? dmem_addr  : imem_addr)  : '0;

  assign imem_gnt  = mem_req && mem_gnt && !sel_d;
  assign dmem_gnt  = mem_req && mem_gnt &&  sel_d;
  assign push      = mem_req && mem_gnt;

  assign head_i    = g_resetn && !empty && (head == ARB_ID_IMEM);
  assign head_d    = g_resetn && !empty && (head == ARB_ID_DMEM);
  assign imem_recv = head_i && mem_recv;
  assign dmem_recv = head_d && mem_recv;
  assign mem_ack   = (head_i && imem_ack) || (head_d && dmem_ack);
  assign pop       = mem_recv && mem_ack;

  assign imem_rdata = g_resetn ? mem_rdata : '0;
  assign dmem_rdata = g_resetn ? mem_rdata : '0;
  assign imem_error = g_resetn && mem_error;
  assign dmem_error = g_resetn && mem_error;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      lock    <= IDLE;
      rr_d    <= 1'b1;
      arb_err <= 1'b0;
    end else begin
      if (mem_recv && empty) arb_err <= 1'b1;
      if (push) begin
        lock <= IDLE;
        rr_d <= !sel_d;
      end else if (mem_req) begin
        lock <= sel_d ? LOCK_D : LOCK_I;
      end else begin
        lock <= IDLE;
      end
    end
  end

  frv_mem_arb_idq #(.DEPTH(OUTSTANDING)) u_idq (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .push     (push),
    .id       (sel_d ? ARB_ID_DMEM : ARB_ID_IMEM),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

endmodule

// File: tb/tb_frv_mem_arbiter.sv
// Directed bench for frv_mem_arbiter: single-channel fetch, alternating
// round-robin, FIFO-full backpressure, lock hold, unexpected response, reset.
module tb_frv_mem_arbiter;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        imem_req, imem_wen, imem_ack;
  logic [3:0]  imem_strb;
  logic [31:0] imem_wdata, imem_addr;
  logic        imem_gnt, imem_recv, imem_error;
  logic [31:0] imem_rdata;
  logic        dmem_req, dmem_wen, dmem_ack;
  logic [3:0]  dmem_strb;
  logic [31:0] dmem_wdata, dmem_addr;
  logic        dmem_gnt, dmem_recv, dmem_error;
  logic [31:0] dmem_rdata;
  logic        mem_req, mem_wen, mem_gnt, mem_recv, mem_error, mem_ack;
  logic [3:0]  mem_strb;
  logic [31:0] mem_wdata, mem_addr, mem_rdata;
  logic        arb_err;

  int total = 0;
  int bad   = 0;

  always #5 g_clk = ~g_clk;

  frv_mem_arbiter #(.OUTSTANDING(2), .XLEN(32)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .imem_req(imem_req), .imem_wen(imem_wen), .imem_strb(imem_strb),
    .imem_wdata(imem_wdata), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_recv(imem_recv), .imem_ack(imem_ack), .imem_error(imem_error),
    .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
    .dmem_wdata(dmem_wdata), .dmem_addr(dmem_addr), .dmem_gnt(dmem_gnt),
    .dmem_recv(dmem_recv), .dmem_ack(dmem_ack), .dmem_error(dmem_error),
    .dmem_rdata(dmem_rdata),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_strb(mem_strb),
    .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_recv(mem_recv), .mem_error(mem_error), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .arb_err(arb_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge g_clk);
  endtask

  initial begin
    g_resetn = 1'b0;
    imem_req = 0; imem_wen = 0; imem_strb = 0; imem_wdata = 0; imem_addr = 0; imem_ack = 0;
    dmem_req = 0; dmem_wen = 0; dmem_strb = 0; dmem_wdata = 0; dmem_addr = 0; dmem_ack = 0;
    mem_gnt = 0; mem_recv = 0; mem_error = 0; mem_rdata = 0;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_imem_gnt", imem_gnt, 0);
    chk("rst_dmem_recv", dmem_recv, 0);
    chk("rst_mem_ack", mem_ack, 0);
    chk("rst_arb_err", arb_err, 0);
    nxt(); nxt();
    g_resetn = 1'b1;

    // 1: single fetch, response two cycles later
    nxt(); imem_req = 1; imem_addr = 32'h100; mem_gnt = 1; #1;
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_imem_gnt", imem_gnt, 1);
    chk("t1_dmem_gnt", dmem_gnt, 0);
    nxt(); imem_req = 0; mem_gnt = 0; #1;
    chk("t1_idle_req", mem_req, 0);
    nxt(); mem_recv = 1; mem_rdata = 32'hDEADBEEF; imem_ack = 1; #1;
    chk("t1_imem_recv", imem_recv, 1);
    chk("t1_imem_rdata", imem_rdata, 32'hDEADBEEF);
    chk("t1_dmem_recv", dmem_recv, 0);
    chk("t1_mem_ack", mem_ack, 1);
    nxt(); mem_recv = 0; imem_ack = 0; #1;
    chk("t1_recv_done", imem_recv, 0);
    chk("t1_arb_err", arb_err, 0);

    // 2: both request every cycle; grants alternate D,I,D,I
    for (int k = 0; k < 4; k++) begin
      logic exp_d;
      nxt();
      if (k == 0) begin
        imem_req = 1; dmem_req = 1; mem_gnt = 1;
        imem_addr = 32'h200; dmem_addr = 32'h300;
        dmem_wen = 1; dmem_strb = 4'hF; dmem_wdata = 32'hAA;
        imem_ack = 1; dmem_ack = 1;
      end
      mem_recv = (k > 0); mem_rdata = 32'h1000 + k;
      #1;
      exp_d = (k % 2 == 0);
      chk("t2_dmem_gnt", dmem_gnt, exp_d);
      chk("t2_imem_gnt", imem_gnt, !exp_d);
      chk("t2_mem_addr", mem_addr, exp_d ? 32'h300 : 32'h200);
      chk("t2_mem_wen", mem_wen, exp_d);
      if (k > 0) begin
        chk("t2_dmem_recv", dmem_recv, !exp_d);
        chk("t2_imem_recv", imem_recv, exp_d);
      end
    end
    nxt(); imem_req = 0; dmem_req = 0; dmem_wen = 0; mem_recv = 1; mem_rdata = 32'h2000; #1;
    chk("t2_last_imem_recv", imem_recv, 1);
    chk("t2_last_dmem_recv", dmem_recv, 0);
    chk("t2_last_req", mem_req, 0);

    // 3: third request held while two are outstanding
    nxt(); mem_recv = 0; imem_req = 1; imem_addr = 32'h600; mem_gnt = 1; #1;
    chk("t3_gnt1", imem_gnt, 1);
    nxt(); #1;
    chk("t3_gnt2", imem_gnt, 1);
    nxt(); #1;
    chk("t3_full_req", mem_req, 0);
    chk("t3_full_gnt", imem_gnt, 0);
    nxt(); #1;
    chk("t3_full_req2", mem_req, 0);
    nxt(); mem_recv = 1; mem_rdata = 32'h33; #1;
    chk("t3_pop_recv", imem_recv, 1);
    chk("t3_pop_req", mem_req, 0);
    chk("t3_pop_gnt", imem_gnt, 0);
    nxt(); mem_recv = 0; #1;
    chk("t3_gnt3_req", mem_req, 1);
    chk("t3_gnt3", imem_gnt, 1);
    nxt(); imem_req = 0; mem_gnt = 0; mem_recv = 1; #1;
    chk("t3_drain1", imem_recv, 1);
    nxt(); #1;
    chk("t3_drain2", imem_recv, 1);

    // 4: imem locked while mem_gnt is low, dmem then granted
    nxt(); mem_recv = 0; imem_req = 1; imem_addr = 32'h400; #1;
    chk("t4_req", mem_req, 1);
    chk("t4_addr0", mem_addr, 32'h400);
    chk("t4_gnt0", imem_gnt, 0);
    nxt(); dmem_req = 1; dmem_addr = 32'h500; #1;
    chk("t4_addr1", mem_addr, 32'h400);
    chk("t4_dgnt1", dmem_gnt, 0);
    nxt(); #1;
    chk("t4_addr2", mem_addr, 32'h400);
    nxt(); mem_gnt = 1; #1;
    chk("t4_igrant", imem_gnt, 1);
    chk("t4_igrant_d", dmem_gnt, 0);
    chk("t4_addr3", mem_addr, 32'h400);
    nxt(); imem_addr = 32'h404; #1;
    chk("t4_dgrant", dmem_gnt, 1);
    chk("t4_dgrant_i", imem_gnt, 0);
    chk("t4_daddr", mem_addr, 32'h500);
    nxt(); imem_req = 0; dmem_req = 0; mem_gnt = 0; mem_recv = 1; mem_rdata = 32'h44; #1;
    chk("t4_resp_i", imem_recv, 1);
    chk("t4_resp_i_d", dmem_recv, 0);
    nxt(); mem_rdata = 32'h55; #1;
    chk("t4_resp_d", dmem_recv, 1);
    chk("t4_resp_d_i", imem_recv, 0);
    chk("t4_dmem_rdata", dmem_rdata, 32'h55);

    // 5: response with nothing outstanding
    nxt(); mem_recv = 1; #1;
    chk("t5_mem_ack", mem_ack, 0);
    chk("t5_imem_recv", imem_recv, 0);
    chk("t5_dmem_recv", dmem_recv, 0);
    nxt(); mem_recv = 0; #1;
    chk("t5_arb_err", arb_err, 1);
    nxt(); nxt(); #1;
    chk("t5_arb_err_sticky", arb_err, 1);

    // 6: reset with two outstanding and a response held across it
    nxt(); imem_req = 1; dmem_req = 1; mem_gnt = 1; imem_addr = 32'h700; dmem_addr = 32'h800; #1;
    chk("t6_pre_igrant", imem_gnt, 1);
    nxt(); #1;
    chk("t6_pre_dgrant", dmem_gnt, 1);
    nxt(); mem_rdata = 32'h99; mem_recv = 1; g_resetn = 0; #1;
    chk("t6_rst_mem_req", mem_req, 0);
    chk("t6_rst_imem_gnt", imem_gnt, 0);
    chk("t6_rst_dmem_gnt", dmem_gnt, 0);
    chk("t6_rst_mem_ack", mem_ack, 0);
    chk("t6_rst_imem_recv", imem_recv, 0);
    chk("t6_rst_dmem_recv", dmem_recv, 0);
    chk("t6_rst_arb_err", arb_err, 0);
    chk("t6_rst_mem_addr", mem_addr, 0);
    chk("t6_rst_imem_rdata", imem_rdata, 0);
    nxt(); nxt(); g_resetn = 1; #1;
    chk("t6_post_req", mem_req, 1);
    chk("t6_post_dgnt", dmem_gnt, 1);
    chk("t6_post_ignt", imem_gnt, 0);
    chk("t6_post_addr", mem_addr, 32'h800);
    chk("t6_post_ack", mem_ack, 0);
    chk("t6_post_irecv", imem_recv, 0);
    chk("t6_post_drecv", dmem_recv, 0);
    chk("t6_post_err0", arb_err, 0);
    nxt(); imem_req = 0; dmem_req = 0; mem_gnt = 0; #1;
    chk("t6_post_err1", arb_err, 1);
    chk("t6_post_drecv1", dmem_recv, 1);
    nxt(); mem_recv = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
